// File: rtl/lsu_mem_master_if.sv
// Handshake and memory-port bundle for lsu_mem_master.
// The master modport is the LSU's view; the slave modport is the view of whatever drives it and answers for memory.
interface lsu_mem_master_if #(
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic            in_we;
    logic [1:0]      in_size;
    logic            in_unsigned;
    logic [63:0]     in_addr;
    logic [63:0]     in_wdata;
    logic [RD_W-1:0] in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_rdata;
    logic [RD_W-1:0] out_rd;
    logic            out_err;

    logic            mem_ce;
    logic            mem_we;
    logic [63:0]     mem_addr;
    logic [63:0]     mem_wdata;
    logic [7:0]      mem_wmask;
    logic [63:0]     mem_rdata;
    logic            mem_rvalid;

    modport master (
        input  in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        input  out_ready, mem_rdata, mem_rvalid,
        output in_ready, out_valid, out_rdata, out_rd, out_err,
        output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, in_rd,
        output out_ready, mem_rdata, mem_rvalid,
        input  in_ready, out_valid, out_rdata, out_rd, out_err,
        input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator: aligned 64-bit memory requests, load extraction and extension.
// Define LSU_TIMEOUT_EN to abort a request that waits TIMEOUT_CYCLES without mem_rvalid.
module lsu_mem_master #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RD_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            w_accept;
    logic            w_memDone;
    logic            w_tmoHit;
    logic            w_misaligned;
    logic [7:0]      w_sizeMask;
    logic [63:0]     w_laneData;
    logic [63:0]     w_loadData;

    logic            r_memWe;
    logic [63:0]     r_memAddr;
    logic [63:0]     r_memWdata;
    logic [7:0]      r_memWmask;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [2:0]      r_byteOff;
    logic [63:0]     r_outRdata;
    logic [RD_W-1:0] r_outRd;
    logic            r_outErr;

    if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_tmoCnt;

    // Count idle REQ cycles; anything outside REQ keeps the counter at zero so every request starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmoCnt <= '0;
        end else if (r_state != REQ) begin
            r_tmoCnt <= '0;
        end else if (!bus.mem_rvalid) begin
            r_tmoCnt <= r_tmoCnt + CNT_W'(1);
        end
    end
`endif

    always_comb begin
        w_sizeMask   = 8'h01;
        w_misaligned = 1'b0;
        case (bus.in_size)
            2'd0: w_sizeMask = 8'h01;
            2'd1: begin
                w_sizeMask   = 8'h03;
                w_misaligned = bus.in_addr[0];
            end
            2'd2: begin
                w_sizeMask   = 8'h0F;
                w_misaligned = |bus.in_addr[1:0];
            end
            default: begin
                w_sizeMask   = 8'hFF;
                w_misaligned = |bus.in_addr[2:0];
            end
        endcase
    end

    always_comb begin
        w_laneData = bus.mem_rdata >> {r_byteOff, 3'b000};
        w_loadData = w_laneData;
        case (r_size)
            2'd0: w_loadData = r_unsigned ? {56'd0, w_laneData[7:0]}
                                          : {{56{w_laneData[7]}}, w_laneData[7:0]};
            2'd1: w_loadData = r_unsigned ? {48'd0, w_laneData[15:0]}
                                          : {{48{w_laneData[15]}}, w_laneData[15:0]};
            2'd2: w_loadData = r_unsigned ? {32'd0, w_laneData[31:0]}
                                          : {{32{w_laneData[31]}}, w_laneData[31:0]};
            default: w_loadData = w_laneData;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_memDone   = 1'b0;
        w_tmoHit    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = w_misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                // A response arriving on the limit cycle still counts as a normal completion.
                if (bus.mem_rvalid) begin
                    w_memDone   = 1'b1;
                    w_stateNext = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (r_tmoCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_tmoHit    = 1'b1;
                    w_stateNext = RESP;
                end
`endif
            end
            RESP: begin
                if (bus.out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Memory request fields are captured only for aligned requests; a misaligned one never touches memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memWmask <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_byteOff  <= '0;
            r_outRdata <= '0;
            r_outRd    <= '0;
            r_outErr   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (!w_misaligned) begin
                    r_memWe    <= bus.in_we;
                    r_memAddr  <= {bus.in_addr[63:3], 3'b000};
                    r_memWdata <= bus.in_wdata << {bus.in_addr[2:0], 3'b000};
                    r_memWmask <= bus.in_we ? (w_sizeMask << bus.in_addr[2:0]) : 8'h00;
                end
                r_size     <= bus.in_size;
                r_unsigned <= bus.in_unsigned;
                r_byteOff  <= bus.in_addr[2:0];
                r_outRd    <= bus.in_rd;
                r_outRdata <= '0;
                r_outErr   <= w_misaligned;
            end
            if (w_memDone) begin
                r_outRdata <= r_memWe ? 64'd0 : w_loadData;
                r_outErr   <= 1'b0;
            end
            if (w_tmoHit) begin
                r_outRdata <= '0;
                r_outErr   <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == RESP);
    assign bus.mem_ce    = (r_state == REQ);
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.mem_wmask = r_memWmask;
    assign bus.out_rdata = r_outRdata;
    assign bus.out_rd    = r_outRd;
    assign bus.out_err   = r_outErr;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: a small memory responder, directed cases, then random aligned accesses.
// Timeout cases are included when LSU_TIMEOUT_EN is defined.
module tb_lsu_mem_master;
    localparam int RD_W = 5;
    localparam int TMO  = 4;

    typedef struct {
        logic [63:0]     rdata;
        logic [RD_W-1:0] rd;
        logic            err;
    } exp_t;

    logic clk;
    logic rst;
    lsu_mem_master_if #(.RD_W(RD_W)) bus ();

    lsu_mem_master #(.TIMEOUT_CYCLES(TMO), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sbQ[$];
    int          checks     = 0;
    int          errors     = 0;
    int          respCount  = 0;
    int          ceCount    = 0;
    int          ceRun      = 0;
    int          rvDelay    = 0;
    logic        rvEnable   = 1'b1;
    logic        forceRv    = 1'b0;
    logic [63:0] memWord    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: answers rvDelay cycles after mem_ce rises (0 = same cycle).
    always @(negedge clk) begin
        if (bus.mem_ce) begin
            ceRun = ceRun + 1;
            bus.mem_rvalid = (rvEnable && (ceRun - 1 == rvDelay)) || forceRv;
        end else begin
            ceRun = 0;
            bus.mem_rvalid = forceRv;
        end
        bus.mem_rdata = memWord;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.mem_ce) ceCount++;
        if (!rst && bus.out_valid && bus.out_ready) begin
            respCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedResp", 64'd1, 64'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("outRdata", bus.out_rdata, e.rdata);
                checkOutput("outRd", 64'(bus.out_rd), 64'(e.rd));
                checkOutput("outErr", 64'(bus.out_err), 64'(e.err));
            end
        end
    end

    function automatic logic [63:0] modelLoad(input logic [63:0] word, input logic [2:0] off,
                                               input logic [1:0] size, input logic uns);
        logic [63:0] res;
        int n;
        res = '0;
        n = 1 << size;
        for (int i = 0; i < n; i++) res[8*i +: 8] = word[8*(int'(off) + i) +: 8];
        if (!uns && res[8*n-1]) begin
            for (int b = 8*n; b < 64; b++) res[b] = 1'b1;
        end
        return res;
    endfunction

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [RD_W-1:0] rd, input logic [63:0] expRdata,
                                 input logic expErr, input logic expectResp);
        exp_t e;
        for (int i = 0; i < 100 && !bus.in_ready; i++) tick();
        checkOutput("inReadyBeforeAccept", 64'(bus.in_ready), 64'd1);
        bus.in_valid    = 1'b1;
        bus.in_we       = we;
        bus.in_size     = size;
        bus.in_unsigned = uns;
        bus.in_addr     = addr;
        bus.in_wdata    = wdata;
        bus.in_rd       = rd;
        if (expectResp) begin
            e.rdata = expRdata;
            e.rd    = rd;
            e.err   = expErr;
            sbQ.push_back(e);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResp(input int target);
        for (int i = 0; i < 200 && respCount < target; i++) tick();
        checkOutput("respArrived", 64'(respCount >= target), 64'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [2:0]  off;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] expW;
        logic [7:0]  expM;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_we = 1'b0;
        bus.in_size = 2'd0;
        bus.in_unsigned = 1'b0;
        bus.in_addr = '0;
        bus.in_wdata = '0;
        bus.in_rd = '0;
        bus.out_ready = 1'b1;
        bus.mem_rdata = '0;
        bus.mem_rvalid = 1'b0;
        repeat (3) tick();

        checkOutput("rstInReady", 64'(bus.in_ready), 64'd1);
        checkOutput("rstOutValid", 64'(bus.out_valid), 64'd0);
        checkOutput("rstOutErr", 64'(bus.out_err), 64'd0);
        checkOutput("rstOutRdata", bus.out_rdata, 64'd0);
        checkOutput("rstOutRd", 64'(bus.out_rd), 64'd0);
        checkOutput("rstMemCe", 64'(bus.mem_ce), 64'd0);
        checkOutput("rstMemWe", 64'(bus.mem_we), 64'd0);
        checkOutput("rstMemAddr", bus.mem_addr, 64'd0);
        checkOutput("rstMemWdata", bus.mem_wdata, 64'd0);
        checkOutput("rstMemWmask", 64'(bus.mem_wmask), 64'd0);
        rst = 1'b0;
        tick();

        // mem_rvalid in IDLE must not start anything
        forceRv = 1'b1;
        repeat (3) tick();
        forceRv = 1'b0;
        tick();
        checkOutput("idleRvalidIgnored", 64'(bus.out_valid), 64'd0);

        // signed byte load
        memWord = 64'h00000000_80000000;
        rvDelay = 1;
        applyStimulus(1'b0, 2'd0, 1'b0, 64'h80000003, 64'd0, 5'd1, 64'hFFFFFFFFFFFFFF80, 1'b0, 1'b1);
        checkOutput("lbMemCe", 64'(bus.mem_ce), 64'd1);
        checkOutput("lbMemAddr", bus.mem_addr, 64'h80000000);
        checkOutput("lbMemWmask", 64'(bus.mem_wmask), 64'd0);
        checkOutput("lbMemWe", 64'(bus.mem_we), 64'd0);
        waitResp(1);

        // unsigned word, signed half, unsigned byte, double
        memWord = 64'h89ABCDEF_01234567;
        rvDelay = 0;
        applyStimulus(1'b0, 2'd2, 1'b1, 64'h80000004, 64'd0, 5'd2, 64'h0000000089ABCDEF, 1'b0, 1'b1);
        waitResp(2);
        memWord = 64'h00000000_F00D0000;
        applyStimulus(1'b0, 2'd1, 1'b0, 64'h80000002, 64'd0, 5'd3, 64'hFFFFFFFFFFFFF00D, 1'b0, 1'b1);
        waitResp(3);
        memWord = 64'h00009A00_00000000;
        applyStimulus(1'b0, 2'd0, 1'b1, 64'h80000005, 64'd0, 5'd4, 64'h000000000000009A, 1'b0, 1'b1);
        waitResp(4);
        memWord = 64'hFEDCBA98_76543210;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h80000008, 64'd0, 5'd5, 64'hFEDCBA9876543210, 1'b0, 1'b1);
        waitResp(5);

        // store half, held for several cycles; in_valid while busy is ignored
        rvDelay = 3;
        applyStimulus(1'b1, 2'd1, 1'b0, 64'h80000006, 64'h1234, 5'd6, 64'd0, 1'b0, 1'b1);
        checkOutput("shMemWe", 64'(bus.mem_we), 64'd1);
        checkOutput("shMemWmask", 64'(bus.mem_wmask), 64'hC0);
        checkOutput("shMemWdata", bus.mem_wdata, 64'h1234000000000000);
        bus.in_valid = 1'b1;
        bus.in_addr  = 64'h100;
        bus.in_we    = 1'b0;
        tick();
        tick();
        bus.in_valid = 1'b0;
        checkOutput("shHeldCe", 64'(bus.mem_ce), 64'd1);
        checkOutput("shHeldAddr", bus.mem_addr, 64'h80000000);
        checkOutput("shHeldWdata", bus.mem_wdata, 64'h1234000000000000);
        checkOutput("shHeldWmask", 64'(bus.mem_wmask), 64'hC0);
        waitResp(6);
        repeat (3) tick();
        checkOutput("busyInValidIgnored", 64'(respCount), 64'd6);

        // misaligned double with a stalled consumer
        bus.out_ready = 1'b0;
        ceCount = 0;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h80000004, 64'd0, 5'd7, 64'd0, 1'b1, 1'b1);
        checkOutput("misOutValid", 64'(bus.out_valid), 64'd1);
        checkOutput("misOutErr", 64'(bus.out_err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("misHoldValid", 64'(bus.out_valid), 64'd1);
            checkOutput("misHoldErr", 64'(bus.out_err), 64'd1);
            checkOutput("misHoldInReady", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        waitResp(7);
        checkOutput("misNoMemCe", 64'(ceCount), 64'd0);

        // minimum latency and back-to-back
        rvDelay = 0;
        memWord = 64'h11223344_55667788;
        applyStimulus(1'b0, 2'd2, 1'b1, 64'h80000000, 64'd0, 5'd8, 64'h0000000055667788, 1'b0, 1'b1);
        checkOutput("b2bCycle1Ce", 64'(bus.mem_ce), 64'd1);
        tick();
        checkOutput("b2bCycle2Valid", 64'(bus.out_valid), 64'd1);
        checkOutput("b2bCycle2InReady", 64'(bus.in_ready), 64'd0);
        tick();
        checkOutput("b2bCycle3InReady", 64'(bus.in_ready), 64'd1);
        applyStimulus(1'b0, 2'd1, 1'b1, 64'h80000006, 64'd0, 5'd9, 64'h0000000000001122, 1'b0, 1'b1);
        waitResp(9);

        // async reset during REQ abandons the access
        rvDelay = 5;
        applyStimulus(1'b0, 2'd0, 1'b0, 64'h80000000, 64'd0, 5'd10, 64'd0, 1'b0, 1'b0);
        checkOutput("rstReqCe", 64'(bus.mem_ce), 64'd1);
        #2 rst = 1'b1;
        #1 checkOutput("rstAsyncCeDrop", 64'(bus.mem_ce), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("rstNoResponse", 64'(respCount), 64'd9);
        checkOutput("rstBackIdle", 64'(bus.in_ready), 64'd1);

`ifdef LSU_TIMEOUT_EN
        rvEnable = 1'b0;
        ceCount = 0;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h80000000, 64'd0, 5'd11, 64'd0, 1'b1, 1'b1);
        waitResp(10);
        checkOutput("tmoCeCycles", 64'(ceCount), 64'(TMO));
        rvEnable = 1'b1;
        rvDelay = TMO - 1;
        memWord = 64'hCAFEF00D_DEADBEEF;
        ceCount = 0;
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h80000000, 64'd0, 5'd12, 64'hCAFEF00DDEADBEEF, 1'b0, 1'b1);
        waitResp(11);
        checkOutput("tmoLastCycleCe", 64'(ceCount), 64'(TMO));
`endif

        // random aligned loads and stores against a byte-wise model
        for (int k = 0; k < 12; k++) begin
            sz      = 2'($urandom_range(0, 3));
            off     = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
            we      = 1'($urandom_range(0, 1));
            addr    = {$urandom, $urandom};
            addr[2:0] = off;
            wdata   = {$urandom, $urandom};
            memWord = {$urandom, $urandom};
            rvDelay = $urandom_range(0, 2);
            expW = '0;
            for (int i = 0; i < 8 - int'(off); i++) expW[8*(i + int'(off)) +: 8] = wdata[8*i +: 8];
            expM = '0;
            if (we) begin
                for (int i = 0; i < (1 << sz); i++) expM[int'(off) + i] = 1'b1;
            end
            applyStimulus(we, sz, 1'($urandom_range(0, 1)), addr, wdata, 5'(k + 16), 64'd0, 1'b0, 1'b0);
            sbQ.push_back('{rdata: we ? 64'd0 : modelLoad(memWord, off, sz, bus.in_unsigned),
                            rd: 5'(k + 16), err: 1'b0});
            checkOutput("rndMemAddr", bus.mem_addr, {addr[63:3], 3'b000});
            checkOutput("rndMemWmask", 64'(bus.mem_wmask), 64'(expM));
            checkOutput("rndMemWdata", bus.mem_wdata, expW);
            waitResp(respCount + 1);
        end

        repeat (3) tick();
        checkOutput("scoreboardEmpty", 64'(sbQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the execute stage and the DPI-backed data memory port (ce/we/addr/wdata/wmask/rdata).
- Accepts one load or store per handshake and drives a 64-bit, 8-byte-aligned memory request with byte mask and lane-shifted data.
- Waits for the memory response, then extracts the addressed bytes and sign- or zero-extends them.
- Returns the result to writeback over a valid/ready handshake. One outstanding access at a time.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles mem_ce may stay high without mem_rvalid (used only with LSU_TIMEOUT_EN).
- RD_W, 5, width of the destination-register tag passed through.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&in_ready.
- in_we  in  1  1=store, 0=load.
- in_size  in  2  0=byte 1=half 2=word 3=double.
- in_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- in_addr  in  64  byte address.
- in_wdata  in  64  store data, right-aligned.
- in_rd  in  RD_W  destination tag.
- out_valid  out  1  response valid.
- out_ready  in  1  response consumed when out_valid&out_ready.
- out_rdata  out  64  extended load data; 0 for stores and errors.
- out_rd  out  RD_W  tag echoed.
- out_err  out  1  misaligned access or timeout.
- mem_ce  out  1  memory request enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  {addr[63:3],3'b000}.
- mem_wdata  out  64  in_wdata << (8*addr[2:0]).
- mem_wmask  out  8  size mask << addr[2:0].
- mem_rdata  in  64  memory read data, valid with mem_rvalid.
- mem_rvalid  in  1  memory response/ack for both loads and stores; may assert in the same cycle mem_ce first rises.

Behaviour:
- Reset (async, immediate): state=IDLE. in_ready=1; out_valid=0; out_err=0; out_rdata=0; out_rd=0; mem_ce=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_wmask=0.
- FSM states: IDLE, REQ, RESP.
- in_ready = (state==IDLE). All request fields register on accept.
- Size masks before shift: 8'h01 (byte), 8'h03 (half), 8'h0F (word), 8'hFF (double).
- Misaligned when any of the following is nonzero: half addr[0]; word addr[1:0]; double addr[2:0].
- IDLE, accept, aligned -> REQ. mem_ce=1 from the next cycle; mem_we/mem_addr/mem_wdata/mem_wmask registered from the request.
- IDLE, accept, misaligned -> RESP with out_err=1, out_rdata=0. No memory access: mem_ce stays 0.
- REQ: mem_ce and all mem_* fields held stable until mem_rvalid is sampled high. A combinational memory may therefore see a repeated identical write, which is idempotent.
- On mem_rvalid in REQ: mem_ce=0 next cycle; state -> RESP.
  - Load: out_rdata = extend((mem_rdata >> 8*addr[2:0]) truncated to size), sign from the top bit of the size unless in_unsigned; double passes through unchanged.
  - Store: out_rdata=0. out_err=0 in both cases.
- RESP: out_valid=1, outputs stable until out_ready. On handshake -> IDLE, out_valid=0. out_rdata/out_rd/out_err hold their last values (don't-care).
- Minimum latency, memory answering in the first REQ cycle:
  - accept at cycle 0; mem_ce high cycle 1; out_valid cycle 2; next accept cycle 3 at the earliest.
- mem_rvalid sampled in IDLE or RESP is ignored.
- in_valid is ignored outside IDLE.
- Reset mid-REQ drops mem_ce immediately; the access is abandoned and no response is produced.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Counter clears on entry to REQ and increments each REQ cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES: mem_ce=0 next cycle; RESP with out_err=1, out_rdata=0.
  - mem_rvalid in the same cycle the count hits the limit wins (normal completion).
- LSU_TIMEOUT_EN undefined: no counter. REQ waits indefinitely for mem_rvalid.

Test Plan:
- Load byte signed, in_addr=0x80000003, mem_rdata=0x00000000_80000000 with 1-cycle-later rvalid -> mem_addr=0x80000000, mem_wmask=0, out_rdata=0xFFFFFFFFFFFFFF80, out_err=0.
- Load word unsigned, addr=0x80000004, mem_rdata=0x89ABCDEF_01234567 -> out_rdata=0x0000000089ABCDEF.
- Store half, addr=0x80000006, in_wdata=0x1234 -> mem_we=1, mem_wmask=0xC0, mem_wdata=0x1234_0000_0000_0000, held until mem_rvalid, then out_valid with out_rdata=0.
- Misaligned double at addr=0x80000004 -> mem_ce never asserts, out_valid next cycle with out_err=1; with out_ready low for 3 cycles, out_valid/out_err stay high and in_ready=0.
- Back-to-back: rvalid in the first REQ cycle and out_ready=1 -> in_ready returns 1 in cycle 3. Async rst pulse during REQ -> mem_ce=0 in the same cycle, no out_valid afterwards.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_rvalid never asserted -> mem_ce high exactly 4 cycles, then out_err=1. Rerun with rvalid on the 4th REQ cycle -> out_err=0.
